// File: rtl/rv_core_pkg.sv
// Shared core types: register index / data word types and the
// operand sequencer state encoding.
package rv_core_pkg;

  localparam int RV_XLEN       = 32;
  localparam int RV_NREGS_LOG2 = 5;

  typedef logic [RV_NREGS_LOG2-1:0] reg_idx_t;
  typedef logic [RV_XLEN-1:0]       word_t;

  // x0 is hard-wired zero; the sequencer never issues a write to it.
  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ1,
    ST_READ2,
    ST_OPS,
    ST_WB,
    ST_DBG,
    ST_DBG_ACK
  } seq_state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Time-multiplexes the single-port register file: two serial operand
// reads plus one writeback per instruction, and round-robin sharing of
// the port with a debug requester.
module regfile_sequencer
  import rv_core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // decoder request
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [NREGS_LOG2-1:0] dec_rs1,
  input  logic [NREGS_LOG2-1:0] dec_rs2,
  // operands to ALU
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  // writeback
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic                  wb_en,
  input  logic [NREGS_LOG2-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  // debug access
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [NREGS_LOG2-1:0] dbg_idx,
  input  logic [XLEN-1:0]       dbg_wdata,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_rdata,
  // register file port
  output logic [NREGS_LOG2-1:0] rf_idx,
  output logic                  rf_write,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [XLEN-1:0]       rf_rdata
);

  localparam logic [NREGS_LOG2-1:0] IDX_ZERO = NREGS_LOG2'(REG_ZERO);

  seq_state_e            state_q, state_d;
  logic [NREGS_LOG2-1:0] rs1_q, rs1_d;
  logic [NREGS_LOG2-1:0] rs2_q, rs2_d;
  logic [NREGS_LOG2-1:0] dbg_idx_q, dbg_idx_d;
  logic                  dbg_we_q, dbg_we_d;
  logic [XLEN-1:0]       dbg_wdata_q, dbg_wdata_d;
  logic [XLEN-1:0]       op_a_q, op_a_d;
  logic [XLEN-1:0]       op_b_q, op_b_d;
  logic [XLEN-1:0]       dbg_rdata_q, dbg_rdata_d;
  // Set after a decoder grant so debug takes the next conflict; clear
  // after a debug grant (and out of reset) so the decoder takes it.
  logic                  last_dbg_q, last_dbg_d;
  logic                  op_valid_q, op_valid_d;
  logic                  wb_ready_q, wb_ready_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic                  dbg_wins;

  // Next-state, capture and register-file port decode for every state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    dbg_idx_d   = dbg_idx_q;
    dbg_we_d    = dbg_we_q;
    dbg_wdata_d = dbg_wdata_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    dbg_rdata_d = dbg_rdata_q;
    last_dbg_d  = last_dbg_q;
    dec_ready   = 1'b0;
    rf_idx      = '0;
    rf_write    = 1'b0;
    rf_wdata    = '0;
    dbg_wins    = dbg_req && (!dec_valid || last_dbg_q);

    unique case (state_q)
      ST_IDLE: begin
        if (dbg_wins) begin
          dbg_idx_d   = dbg_idx;
          dbg_we_d    = dbg_we;
          dbg_wdata_d = dbg_wdata;
          last_dbg_d  = 1'b0;
          state_d     = ST_DBG;
        end else if (dec_valid) begin
          dec_ready  = 1'b1;
          rs1_d      = dec_rs1;
          rs2_d      = dec_rs2;
          last_dbg_d = 1'b1;
          state_d    = ST_READ1;
        end
      end
      ST_READ1: begin
        rf_idx  = rs1_q;
        op_a_d  = rf_rdata;
        state_d = ST_READ2;
      end
      ST_READ2: begin
        rf_idx  = rs2_q;
        op_b_d  = rf_rdata;
        state_d = ST_OPS;
      end
      ST_OPS: begin
        if (op_ready) state_d = ST_WB;
      end
      ST_WB: begin
        if (wb_valid) begin
          rf_idx   = wb_rd;
          rf_wdata = wb_data;
          rf_write = wb_en && (wb_rd != IDX_ZERO);
          state_d  = ST_IDLE;
        end
      end
      ST_DBG: begin
        rf_idx      = dbg_idx_q;
        rf_wdata    = dbg_wdata_q;
        rf_write    = dbg_we_q && (dbg_idx_q != IDX_ZERO);
        dbg_rdata_d = rf_rdata;  // value before this cycle's write lands
        state_d     = ST_DBG_ACK;
      end
      ST_DBG_ACK: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    op_valid_d = (state_d == ST_OPS);
    wb_ready_d = (state_d == ST_WB);
    dbg_ack_d  = (state_d == ST_DBG_ACK);
  end

  // State, captured operands and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      dbg_idx_q   <= '0;
      dbg_we_q    <= 1'b0;
      dbg_wdata_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      dbg_rdata_q <= '0;
      last_dbg_q  <= 1'b0;
      op_valid_q  <= 1'b0;
      wb_ready_q  <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      dbg_idx_q   <= dbg_idx_d;
      dbg_we_q    <= dbg_we_d;
      dbg_wdata_q <= dbg_wdata_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      dbg_rdata_q <= dbg_rdata_d;
      last_dbg_q  <= last_dbg_d;
      op_valid_q  <= op_valid_d;
      wb_ready_q  <= wb_ready_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign wb_ready  = wb_ready_q;
  assign dbg_ack   = dbg_ack_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
